// File: rtl/add_pkg.sv
// Shared types and default sizing for the adder responder slice.
package add_pkg;

  localparam int ADD_WIDTH = 4;
  localparam int ADD_DEPTH = 4;

  typedef logic [ADD_WIDTH:0] sum_t;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] a;
    logic [ADD_WIDTH-1:0] b;
  } operands_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. The level counter tells full from empty; the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH_D = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH_D-1:0]       wdata,
  output logic [WIDTH_D-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH_D-1:0] mem_q [DEPTH];
  logic [WIDTH_D-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Head is forced to zero when empty so stale or never-written storage is never shown.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/add_responder.sv
// Accepts operand pairs, buffers their widened sums in a FIFO and returns them in order.
module add_responder
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DEPTH = ADD_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_y,
  output logic [CNT_W-1:0]         txn_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  logic             full, empty;
  logic             push, pop;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  function automatic logic [WIDTH:0] widen_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Ready depends only on registered level, so a pop never frees a slot in the same cycle.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign sum       = widen_add(in_a, in_b);
  assign txn_count = txn_count_q;

  always_comb begin
    txn_count_d = txn_count_q;
    if (push) begin
      txn_count_d = txn_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_q <= '0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  sync_fifo #(
    .WIDTH_D (WIDTH + 1),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (sum),
    .rdata (out_y),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_add_responder.sv
// Randomised and directed bench for add_responder against a queue-based reference model.
module tb_add_responder;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     out_y;
  logic [CW-1:0]  txn_count;
  logic [$clog2(D):0] fifo_level;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int exp_cnt = 0;

  always #5 clk = ~clk;

  add_responder #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .txn_count  (txn_count),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit v, input int a, input int b, input bit ordy,
                      output bit accepted);
    int  n;
    bit  do_push, do_pop;
    rst       = r;
    in_valid  = v;
    in_a      = W'(a);
    in_b      = W'(b);
    out_ready = ordy;
    @(negedge clk);
    n = exp_q.size();
    chk("fifo_level", 32'(fifo_level), n);
    chk("out_valid",  32'(out_valid),  (n != 0) ? 1 : 0);
    chk("in_ready",   32'(in_ready),   (n != D) ? 1 : 0);
    chk("out_y",      32'(out_y),      (n != 0) ? exp_q[0] : 0);
    chk("txn_count",  32'(txn_count),  exp_cnt);
    accepted = 1'b0;
    if (r) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      do_push = v && (n < D);
      do_pop  = ordy && (n > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back((a % 16) + (b % 16));
        exp_cnt  = (exp_cnt + 1) % (1 << CW);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input bit ordy);
    bit acc;
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0, ordy, acc);
  endtask

  initial begin
    bit acc;
    int tries;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y",     32'(out_y),     0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_txn",       32'(txn_count), 0);
    idle(1, 1'b1);

    // Single transfers, idle FIFO
    step(1'b0, 1'b1, 1, 3, 1'b1, acc);
    chk("single_1_3", 32'(out_y), 4);
    step(1'b0, 1'b1, 5, 6, 1'b1, acc);
    chk("single_5_6", 32'(out_y), 11);
    step(1'b0, 1'b1, 3, 5, 1'b1, acc);
    chk("single_3_5", 32'(out_y), 8);
    chk("single_txn", 32'(txn_count), 3);
    idle(2, 1'b1);

    // Width boundary
    step(1'b0, 1'b1, 15, 15, 1'b1, acc);
    chk("wide_15_15", 32'(out_y), 30);
    step(1'b0, 1'b1, 0, 0, 1'b1, acc);
    chk("wide_0_0", 32'(out_y), 0);
    idle(2, 1'b1);

    // Backpressure fill, fifth pair held until space appears
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, i, i, 1'b0, acc);
    chk("bp_level",    32'(fifo_level), 4);
    chk("bp_in_ready", 32'(in_ready),   0);
    chk("bp_head",     32'(out_y),      2);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 10) begin
      step(1'b0, 1'b1, 5, 5, 1'b1, acc);
      tries++;
    end
    chk("bp_held_accept", 32'(acc), 1);
    idle(6, 1'b1);

    // Concurrent push/pop at level 2
    step(1'b0, 1'b1, 2, 7, 1'b0, acc);
    step(1'b0, 1'b1, 9, 4, 1'b0, acc);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, acc);
    chk("steady_level", 32'(fifo_level), 2);
    idle(4, 1'b1);

    // Random mixed traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 15), ($urandom_range(0, 2) != 0), acc);
    idle(6, 1'b1);

    // Reset mid-operation with a pair presented in the reset cycle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, i + 4, 3, 1'b0, acc);
    chk("pre_rst_level", 32'(fifo_level), 3);
    step(1'b1, 1'b1, 7, 7, 1'b0, acc);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_txn",   32'(txn_count), 0);
    chk("post_rst_ready", 32'(in_ready),  1);
    idle(1, 1'b1);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, i % 16, 1, 1'b1, acc);
    chk("txn_wrap", 32'(txn_count), 1);
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_responder.md
Name: add_responder

Overview:
- Receiving end of the operand stream that the adder stimulus tasks produce.
- Accepts operand pairs (a, b) over a valid/ready handshake, computes the widened sum, and buffers results in a small FIFO.
- Returns results to the initiator over a second valid/ready handshake and keeps a count of accepted transactions.
- Sits between the operand stimulus generator and the response monitor/scoreboard.

Parameters:
- WIDTH, 4, operand width in bits; result width is WIDTH+1.
- DEPTH, 4, result FIFO depth in entries; must be a power of two, at least 2.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  out_y holds a valid result (FIFO head).
- out_ready  input  1  consumer takes the result this cycle.
- out_y  output  WIDTH+1  result, a+b unsigned, no truncation.
- txn_count  output  CNT_W  number of accepted operand pairs since reset; wraps.
- fifo_level  output  $clog2(DEPTH)+1  current number of buffered results.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1, the FIFO empties (read pointer, write pointer and level all 0).
  - After that edge: txn_count=0, out_valid=0, out_y=0, in_ready=1.
  - rst has priority over any simultaneous handshake; a transfer presented in a reset cycle is dropped.
  - Reset mid-operation discards all buffered results.
- Accept: a transfer occurs when in_valid=1 and in_ready=1 at a rising edge.
  - On that edge, {1'b0,in_a}+{1'b0,in_b} is written at the write pointer and txn_count increments.
- Result latency: the result is visible on out_y with out_valid=1 one cycle after accept, provided the FIFO was empty.
  - Otherwise results appear in strict acceptance order.
- Arithmetic: unsigned, with a WIDTH+1 bit result. Example: 15+15=30 (5'b11110), with no overflow flag.
- Pop: a pop occurs when out_valid=1 and out_ready=1 at a rising edge; the read pointer advances.
- Registered outputs:
  - out_y and out_valid are registered, or a direct function of registered FIFO state.
  - There are no combinational paths from in_valid to out_valid, or from out_ready to in_ready.
- Ready and valid:
  - in_ready = (fifo_level != DEPTH).
  - When full, in_ready=0 even if out_ready=1 in the same cycle; this adds one bubble per full-drain, which is intentional.
  - out_valid = (fifo_level != 0).
- Simultaneous push and pop, FIFO not full and not empty: level unchanged and both pointers advance.
- Push to an empty FIFO while out_ready=1: no pop that cycle, because out_valid was 0. The result is presented the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH. The level counter disambiguates full from empty.
- Counter wrap: txn_count wraps from 2^CNT_W-1 to 0 with no saturation.
- Stall stability: while out_valid=1 and out_ready=0, out_y must not change. The same holds for stalled inputs: if in_valid=1 and in_ready=0, the operands are not consumed.
- Unknowns: in_a/in_b are don't-care when in_valid=0 and must not corrupt state.

Decomposition:
- Package add_pkg:
  - localparam defaults ADD_WIDTH=4 and ADD_DEPTH=4.
  - typedef logic [ADD_WIDTH:0] sum_t.
  - typedef struct packed {logic [ADD_WIDTH-1:0] a; logic [ADD_WIDTH-1:0] b;} operands_t.
- Sub-module sync_fifo (parameterised WIDTH_D and DEPTH):
  - Contents: storage, pointers, level, full/empty.
  - add_responder instantiates it and adds the adder, handshake glue and transaction counter.

Test Plan:
- Single transfers, FIFO idle, out_ready=1: (1,3), (5,6), (3,5) on consecutive posedges -> out_y=4, 11, 8, each one cycle after its accept; txn_count=3.
- Width boundary: (15,15) and (0,0) -> out_y=30 then 0; no truncation to 4 bits.
- Backpressure fill: out_ready=0, five back-to-back valid pairs (1,1)..(5,5):
  - in_ready drops after the 4th accept; fifo_level=4; pair (5,5) is held.
  - Releasing out_ready yields 2, 4, 6, 8, then (5,5) is accepted -> 10.
- Concurrent push/pop at level 2: random pairs with out_ready=1 for 20 cycles -> fifo_level stays 2; order matches the scoreboard.
- Reset mid-operation: level=3, rst pulsed for one cycle with in_valid=1 -> next cycle out_valid=0, txn_count=0, in_ready=1; the pair in the reset cycle is not counted.
- Counter wrap with CNT_W=4: 17 accepts -> txn_count reads 1.
